// File: rtl/dj8_bus_pkg.sv
// Shared types and constants for the dj8 pin-side memory responder.
//   state_t     : responder FSM states
//   OE_*        : request encodings carried on the core's uio_oe pins
//   STAT_*      : bit positions inside the status byte returned on ui_in
//   cpu_req_t   : request latched from the pins when a transfer starts
//   make_status : builds a status byte from ready/err flags
package dj8_bus_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [BYTE_W-1:0] OE_IDLE  = 8'h00;
    localparam logic [BYTE_W-1:0] OE_READ  = 8'h0F;
    localparam logic [BYTE_W-1:0] OE_WRITE = 8'hFF;

    localparam int unsigned STAT_READY = 0;
    localparam int unsigned STAT_ERR   = 1;

    typedef struct packed {
        logic              is_write;
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } cpu_req_t;

    // Status byte with only the ready/err bits populated.
    function automatic logic [BYTE_W-1:0] make_status(input logic ready, input logic err);
        logic [BYTE_W-1:0] s;
        s             = '0;
        s[STAT_READY] = ready;
        s[STAT_ERR]   = err;
        return s;
    endfunction

endpackage

// File: rtl/dj8_resp_ram.sv
// Byte RAM behind the dj8 responder: one write port, one synchronous read port.
//   clk, rst : clock; rst clears only the read-data register, not the array
//   we/waddr/wdata : write port (loader or CPU, selected by the parent)
//   re/raddr       : read enable and address; rdata updates on the next edge
//   rdata          : registered read data, held while re is low
module dj8_resp_ram
    import dj8_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem [DEPTH];

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the pin-facing read data, so it holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dj8_mem_responder.sv
// Pin-side memory responder for the dj8 core.
// Services read/write requests encoded on cpu_oe with programmable wait states,
// rejects CPU writes into the read-only region, and accepts a byte stream from
// a loader port that may write anywhere (ROM install).
//   clk, rst        : clock, asynchronous active-high reset
//   cpu_addr/wdata  : address and write data from the core pins
//   cpu_oe          : request type (idle/read/write, anything else is an error)
//   cpu_rdata       : last read data (registered)
//   cpu_status      : bit0 ready, bit1 err (registered)
//   load_valid/data : loader byte stream
//   load_ready      : combinational; loader byte taken when valid && ready
//   load_clear      : returns the loader pointer to 0
module dj8_mem_responder
    import dj8_bus_pkg::*;
#(
    parameter int unsigned     ADDR_W      = 8,
    parameter int unsigned     WAIT_CYCLES = 2,
    parameter logic [BYTE_W-1:0] RO_BASE   = 8'hC0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] cpu_addr,
    input  logic [BYTE_W-1:0] cpu_wdata,
    input  logic [BYTE_W-1:0] cpu_oe,
    output logic [BYTE_W-1:0] cpu_rdata,
    output logic [BYTE_W-1:0] cpu_status,
    input  logic              load_valid,
    input  logic [BYTE_W-1:0] load_data,
    output logic              load_ready,
    input  logic              load_clear
);

    // Counter must hold WAIT_CYCLES itself; keep at least one bit when it is 0.
    localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cpu_req_t           req_q, req_d;
    logic [BYTE_W-1:0]  status_q, status_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [BYTE_W-1:0]  ram_wdata;
    logic               ram_re;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_ro;
    logic               load_accept;

    assign req_addr    = req_q.addr[ADDR_W-1:0];
    assign req_ro      = 32'(req_addr) >= 32'(RO_BASE);
    assign load_ready  = (state_q == ST_IDLE) && (cpu_oe == OE_IDLE);
    assign load_accept = load_valid && load_ready;

    assign cpu_status  = status_q;

    // State, counter, latched request, status and loader pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            status_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            status_q <= status_d;
            ptr_q    <= ptr_d;
        end
    end

    // Next-state, RAM port control and loader pointer update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        status_d  = status_q;
        ptr_d     = ptr_q;
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_wdata = load_data;
        ram_re    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if ((cpu_oe == OE_READ) || (cpu_oe == OE_WRITE)) begin
                    req_d.is_write = (cpu_oe == OE_WRITE);
                    req_d.addr     = cpu_addr;
                    req_d.wdata    = cpu_wdata;
                    cnt_d          = CNT_W'(WAIT_CYCLES);
                    state_d        = ST_WAIT;
                end else if (cpu_oe != OE_IDLE) begin
                    status_d = make_status(1'b0, 1'b1);
                    state_d  = ST_ERR;
                end
            end
            ST_WAIT: begin
                // Dropping the request while waiting abandons it silently.
                if (cpu_oe == OE_IDLE) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    if (req_q.is_write) begin
                        status_d  = make_status(1'b1, req_ro);
                        ram_we    = !req_ro;
                        ram_waddr = req_addr;
                        ram_wdata = req_q.wdata;
                    end else begin
                        status_d = make_status(1'b1, 1'b0);
                        ram_re   = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (cpu_oe == OE_IDLE) begin
                    status_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loader only runs in IDLE with no request, so it never collides with a CPU write.
        if (load_accept) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = load_data;
        end

        // Clear wins over the increment; the accepted byte still lands at the old pointer.
        if (load_clear) begin
            ptr_d = '0;
        end else if (load_accept) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    dj8_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (req_addr),
        .rdata (cpu_rdata)
    );

endmodule

// File: tb/tb_dj8_mem_responder.sv
// Self-checking bench for dj8_mem_responder with a scoreboard of expected
// CPU responses and a reference byte memory tracking loader and CPU writes.
module tb_dj8_mem_responder;
    import dj8_bus_pkg::*;

    localparam int unsigned WAIT_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_addr, cpu_wdata, cpu_oe, cpu_rdata, cpu_status;
    logic       load_valid, load_ready, load_clear;
    logic [7:0] load_data;

    dj8_mem_responder #(
        .ADDR_W      (8),
        .WAIT_CYCLES (WAIT_CYCLES),
        .RO_BASE     (8'hC0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_oe     (cpu_oe),
        .cpu_rdata  (cpu_rdata),
        .cpu_status (cpu_status),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_clear (load_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [7:0]  status;
        logic [7:0]  rdata;
        int unsigned lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_mem [256];
    logic [7:0] model_ptr;
    logic [7:0] last_rdata;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic clr);
        load_valid = 1'b1;
        load_data  = d;
        load_clear = clr;
        #1 check("load_ready", 32'(load_ready), 32'd1);
        tick();
        model_mem[model_ptr] = d;
        model_ptr            = clr ? 8'h00 : model_ptr + 8'h01;
        load_valid = 1'b0;
        load_clear = 1'b0;
    endtask

    task automatic clear_ptr();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
        model_ptr  = 8'h00;
    endtask

    // Issue one request, wait (bounded) for a response, compare it, then release.
    task automatic cpu_op(input string tag, input logic [7:0] oe, input logic [7:0] addr,
                          input logic [7:0] wdata);
        exp_t e;
        int   cyc;
        bit   seen;
        e.tag = tag;
        if (oe == OE_READ) begin
            e.status   = 8'h01;
            e.rdata    = model_mem[addr];
            last_rdata = e.rdata;
            e.lat      = WAIT_CYCLES + 2;
        end else if (oe == OE_WRITE) begin
            if (addr >= 8'hC0) begin
                e.status = 8'h03;
            end else begin
                e.status        = 8'h01;
                model_mem[addr] = wdata;
            end
            e.rdata = last_rdata;
            e.lat   = WAIT_CYCLES + 2;
        end else begin
            e.status = 8'h02;
            e.rdata  = last_rdata;
            e.lat    = 1;
        end
        sb_q.push_back(e);

        cpu_oe    = oe;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                cpu_addr  = ~addr;
                cpu_wdata = ~wdata;
            end
            if (cpu_status != 8'h00) seen = 1'b1;
        end

        e = sb_q.pop_front();
        if (!seen) begin
            check({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({e.tag, "_lat"},    32'(cyc),        32'(e.lat));
            check({e.tag, "_status"}, 32'(cpu_status), 32'(e.status));
            check({e.tag, "_rdata"},  32'(cpu_rdata),  32'(e.rdata));
            repeat (2) begin
                tick();
                check({e.tag, "_hold"},    32'(cpu_status), 32'(e.status));
                check({e.tag, "_rd_hold"}, 32'(cpu_rdata),  32'(e.rdata));
            end
        end
        cpu_oe = OE_IDLE;
        tick();
        check({e.tag, "_release"}, 32'(cpu_status), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst        = 1'b1;
        cpu_oe     = OE_IDLE;
        cpu_addr   = 8'h00;
        cpu_wdata  = 8'h00;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_clear = 1'b0;
        model_ptr  = 8'h00;
        last_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_status", 32'(cpu_status), 32'd0);
        check("reset_rdata",  32'(cpu_rdata),  32'd0);
        check("reset_load_ready", 32'(load_ready), 32'd1);
        tick();

        // Preload then read back through the CPU port.
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b0);
        load_byte(8'hCC, 1'b0);
        cpu_op("rd01", OE_READ, 8'h01, 8'h00);

        // Write then read back; write must not disturb cpu_rdata.
        cpu_op("wr10", OE_WRITE, 8'h10, 8'h5A);
        cpu_op("rd10", OE_READ,  8'h10, 8'h00);

        // Read-only region: loader installs 11 at C4, CPU write is refused.
        while (model_ptr != 8'hC4) load_byte(model_ptr ^ 8'h3C, 1'b0);
        load_byte(8'h11, 1'b0);
        cpu_op("wr_ro", OE_WRITE, 8'hC4, 8'h99);
        cpu_op("rd_ro", OE_READ,  8'hC4, 8'h00);

        // Protocol error, then confirm memory untouched.
        cpu_op("perr", 8'h3C, 8'hC4, 8'h00);
        cpu_op("rd_perr_c4", OE_READ, 8'hC4, 8'h00);
        cpu_op("rd_perr_01", OE_READ, 8'h01, 8'h00);

        // Clear together with an accepted byte: byte lands at old pointer, pointer -> 0.
        load_byte(8'hE7, 1'b1);
        while (model_ptr != 8'h20) load_byte(model_ptr + 8'h70, 1'b0);
        load_byte(8'h44, 1'b0);
        cpu_op("rd_c5", OE_READ, 8'hC5, 8'h00);
        cpu_op("rd_00", OE_READ, 8'h00, 8'h00);

        // Abort a write one edge into WAIT.
        cpu_oe    = OE_WRITE;
        cpu_addr  = 8'h20;
        cpu_wdata = 8'h77;
        tick();
        cpu_oe = OE_IDLE;
        repeat (5) begin
            tick();
            check("abort_status", 32'(cpu_status), 32'd0);
        end
        cpu_op("rd_abort", OE_READ, 8'h20, 8'h00);

        // Pointer wrap: 257 bytes, last one overwrites address 0.
        clear_ptr();
        for (int i = 0; i < 256; i++) load_byte(8'(i), 1'b0);
        load_byte(8'h01, 1'b0);
        cpu_op("rd_wrap0",  OE_READ, 8'h00, 8'h00);
        cpu_op("rd_wrapff", OE_READ, 8'hFF, 8'h00);

        // Reset during WAIT drops the pending write.
        cpu_oe    = OE_WRITE;
        cpu_addr  = 8'h05;
        cpu_wdata = 8'h33;
        tick();
        tick();
        rst = 1'b1;
        #1 check("rst_wait_status", 32'(cpu_status), 32'd0);
        #1 rst = 1'b0;
        cpu_oe    = OE_IDLE;
        model_ptr = 8'h00;
        last_rdata = 8'h00;
        tick();
        cpu_op("rd_rst_wait", OE_READ, 8'h05, 8'h00);

        // Reset while in DONE clears outputs immediately and the loader pointer.
        cpu_oe   = OE_READ;
        cpu_addr = 8'hFF;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (cpu_status != 8'h00) seen = 1'b1;
        end
        if (!seen) check("rst_done_timeout", 32'd0, 32'd1);
        check("pre_rst_rdata", 32'(cpu_rdata), 32'(model_mem[8'hFF]));
        rst = 1'b1;
        #1;
        check("rst_done_status", 32'(cpu_status), 32'd0);
        check("rst_done_rdata",  32'(cpu_rdata),  32'd0);
        #1 rst = 1'b0;
        cpu_oe     = OE_IDLE;
        model_ptr  = 8'h00;
        last_rdata = 8'h00;
        tick();
        load_byte(8'h6D, 1'b0);
        cpu_op("rd_after_rst", OE_READ, 8'h00, 8'h00);
        cpu_op("rd_after_rst1", OE_READ, 8'h01, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
